// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read-side controller.
// State encoding, FIFO depth and default burst/flush parameters.
package fifo_rd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    localparam int FIFO_DEPTH        = 8;
    localparam int DEF_BURST_LEN     = 4;
    localparam int DEF_FLUSH_TIMEOUT = 16;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [OCC_W-1:0] occ_min(
        input logic [OCC_W-1:0] a,
        input logic [OCC_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// FIFO-side and stream-side signals of the read controller.
// master = controller, slave = FIFO plus downstream consumer.
interface fifo_rd_ctrl_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 3
);
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;

    modport master (
        input  fifo_empty,
        input  fifo_full,
        input  fifo_cnt,
        output fifo_rd_en,
        input  fifo_rd_data,
        output out_valid,
        output out_data,
        input  out_ready,
        output busy
    );

    modport slave (
        output fifo_empty,
        output fifo_full,
        output fifo_cnt,
        input  fifo_rd_en,
        output fifo_rd_data,
        input  out_valid,
        input  out_data,
        output out_ready,
        input  busy
    );
endinterface

// File: rtl/rd_out_buf2.sv
// Two-entry valid/ready output buffer, order preserving.
// Write and pop may happen in the same cycle; caller prevents overflow.
module rd_out_buf2 #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occ
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign occ       = cnt;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + {1'b0, wr_en} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side burst controller for the 8-deep FIFO.
// Optional flush timer: define FIFO_RD_TIMEOUT_EN.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W        = 4,
    parameter int CNT_W         = 3,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int FLUSH_TIMEOUT = DEF_FLUSH_TIMEOUT
) (
    input logic          clk,
    input logic          rst,
    fifo_rd_ctrl_if.master bus
);
    localparam logic [OCC_W-1:0] BL = OCC_W'(BURST_LEN);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [OCC_W-1:0] burst_rem;
    logic [OCC_W-1:0] burst_rem_nxt;
    logic             inflight;
    logic [1:0]       buf_occ;
    logic [CNT_W-1:0] cnt_in;
    logic [OCC_W-1:0] occ;
    logic             pop_out;
    logic             credit_ok;
    logic             rd_en;
    logic             tmr_hit;

    assign cnt_in  = bus.fifo_cnt;
    assign occ     = bus.fifo_full ? FULL_OCC : OCC_W'(cnt_in);
    assign pop_out = bus.out_valid & bus.out_ready;

    // At most two words may be buffered or in flight after this cycle.
    assign credit_ok = ({1'b0, buf_occ} + {2'b0, inflight})
                     < (3'd2 + {2'b0, pop_out});

    assign rd_en = (state == BURST) & ~bus.fifo_empty
                 & (burst_rem != '0) & credit_ok;

    assign bus.fifo_rd_en = rd_en;
    assign bus.busy = (state == BURST) | (buf_occ != 2'd0) | inflight;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

    logic [TMR_W-1:0] tmr;
    logic             tmr_cond;

    assign tmr_cond = (state == IDLE) & ~bus.fifo_empty & (occ < BL);
    assign tmr_hit  = tmr_cond & (tmr == TMR_W'(FLUSH_TIMEOUT - 1));

    // Count idle cycles holding a partial burst; clear otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= '0;
        end else if (tmr_cond && !tmr_hit) begin
            tmr <= tmr + 1'b1;
        end else begin
            tmr <= '0;
        end
    end
`else
    assign tmr_hit = 1'b0;
`endif

    // Burst FSM: next state and remaining pop budget.
    always_comb begin
        state_nxt     = state;
        burst_rem_nxt = burst_rem;
        unique case (state)
            IDLE: begin
                if (occ >= BL) begin
                    state_nxt     = BURST;
                    burst_rem_nxt = occ_min(occ, BL);
                end else if (tmr_hit) begin
                    state_nxt     = BURST;
                    burst_rem_nxt = occ;
                end
            end
            BURST: begin
                burst_rem_nxt = burst_rem - OCC_W'(rd_en);
                if (bus.fifo_empty || burst_rem_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // State, budget and in-flight pop registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_rem <= '0;
            inflight  <= 1'b0;
        end else begin
            state     <= state_nxt;
            burst_rem <= burst_rem_nxt;
            inflight  <= rd_en;
        end
    end

    rd_out_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (inflight),
        .wr_data   (bus.fifo_rd_data),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_ready (bus.out_ready),
        .occ       (buf_occ)
    );
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model, in-order scoreboard,
// scenario table, corner sequences and randomized traffic.
module tb_fifo_rd_ctrl;
    import fifo_rd_pkg::*;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.DATA_W(4), .CNT_W(3)) bus ();

    fifo_rd_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural 8x4 FIFO, read data registered one cycle after pop.
    logic [3:0] fq [$];
    logic [3:0] hist [4096];
    int         wr_total = 0;
    bit         wr_req   = 1'b0;
    bit         fifo_clr = 1'b1;
    logic [3:0] wr_val   = 4'd0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (bus.fifo_rd_en && fq.size() > 0)
                bus.fifo_rd_data <= fq.pop_front();
            if (wr_req && fq.size() < 8) begin
                fq.push_back(wr_val);
                hist[wr_total % 4096] = wr_val;
                wr_total++;
            end
        end
        bus.fifo_empty <= (fq.size() == 0);
        bus.fifo_full  <= (fq.size() == 8);
        bus.fifo_cnt   <= 3'(fq.size());
    end

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int cyc, n_rd, n_out, first_rd, last_rd, first_out, last_out;
    bit hold_pend = 1'b0;
    logic [3:0] hold_data = 4'd0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observe the values the next rising edge will use, then advance.
    task automatic tick();
        #1;
        if (hold_pend) begin
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_data", int'(bus.out_data), int'(hold_data));
        end
        if (bus.fifo_rd_en) begin
            chk("rd_on_empty", int'(bus.fifo_empty), 0);
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("out_order", int'(bus.out_data),
                int'(hist[rd_total % 4096]));
            rd_total++;
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset DUT and FIFO, preload n words, release reset.
    task automatic restart(input int n);
        rst       = 1'b0;
        wr_req    = 1'b0;
        hold_pend = 1'b0;
        fifo_clr  = 1'b1;
        tick();
        fifo_clr  = 1'b0;
        tick();
        rd_total = wr_total;
        for (int i = 0; i < n; i++) begin
            wr_req = 1'b1;
            wr_val = 4'(i);
            tick();
        end
        wr_req = 1'b0;
        tick();
        rst       = 1'b1;
        cyc       = 0;
        n_rd      = 0;
        n_out     = 0;
        first_rd  = -1;
        last_rd   = -1;
        first_out = -1;
        last_out  = -1;
    endtask

    function automatic int fifo_left();
        return bus.fifo_full ? 8 : int'(bus.fifo_cnt);
    endfunction

    typedef struct {
        int nwr;
        bit rdy;
        int rd_no;
        int out_no;
        int left_no;
        int rd_to;
        int out_to;
        int left_to;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{0, 1'b1, 0, 0, 0, 0, 0, 0};
        vt[1]  = '{2, 1'b1, 0, 0, 2, 2, 2, 0};
        vt[2]  = '{3, 1'b1, 0, 0, 3, 3, 3, 0};
        vt[3]  = '{4, 1'b1, 4, 4, 0, 4, 4, 0};
        vt[4]  = '{5, 1'b1, 4, 4, 1, 5, 5, 0};
        vt[5]  = '{7, 1'b1, 4, 4, 3, 7, 7, 0};
        vt[6]  = '{8, 1'b1, 8, 8, 0, 8, 8, 0};
        vt[7]  = '{10, 1'b1, 8, 8, 0, 8, 8, 0};
        vt[8]  = '{4, 1'b0, 2, 0, 2, 2, 0, 2};
        vt[9]  = '{6, 1'b0, 2, 0, 4, 2, 0, 4};
        vt[10] = '{8, 1'b0, 2, 0, 6, 2, 0, 6};
        vt[11] = '{3, 1'b0, 0, 0, 3, 2, 0, 1};

        bus.out_ready = 1'b0;

        // Reset values.
        rst = 1'b0;
        run(2);
        chk("rst_rd_en", int'(bus.fifo_rd_en), 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_data", int'(bus.out_data), 0);
        chk("rst_busy", int'(bus.busy), 0);

        // Idle with empty FIFO.
        bus.out_ready = 1'b1;
        restart(0);
        run(50);
        chk("idle_rd", n_rd, 0);
        chk("idle_busy", int'(bus.busy), 0);

        // Threshold burst timing and throughput.
        restart(4);
        run(20);
        chk("thr_first_rd", first_rd, 1);
        chk("thr_n_rd", n_rd, 4);
        chk("thr_last_rd", last_rd, 4);
        chk("thr_first_out", first_out, 3);
        chk("thr_last_out", last_out, 6);
        chk("thr_n_out", n_out, 4);
        chk("thr_busy", int'(bus.busy), 0);

        // Scenario table.
        foreach (vt[k]) begin
            bus.out_ready = vt[k].rdy;
            restart(vt[k].nwr);
            run(60);
            chk($sformatf("tbl%0d_rd", k), n_rd,
                TO ? vt[k].rd_to : vt[k].rd_no);
            chk($sformatf("tbl%0d_out", k), n_out,
                TO ? vt[k].out_to : vt[k].out_no);
            chk($sformatf("tbl%0d_left", k), fifo_left(),
                TO ? vt[k].left_to : vt[k].left_no);
        end

        // Backpressure then release.
        bus.out_ready = 1'b0;
        restart(4);
        run(20);
        chk("bp_n_rd", n_rd, 2);
        chk("bp_valid", int'(bus.out_valid), 1);
        chk("bp_data", int'(bus.out_data), 0);
        chk("bp_busy", int'(bus.busy), 1);
        bus.out_ready = 1'b1;
        run(20);
        chk("bp_n_rd2", n_rd, 4);
        chk("bp_n_out", n_out, 4);
        chk("bp_all_out", rd_total, wr_total);
        chk("bp_empty", int'(bus.fifo_empty), 1);

        // Reset during the second pop.
        bus.out_ready = 1'b1;
        restart(4);
        run(2);
        #1;
        chk("mid_rd_live", int'(bus.fifo_rd_en), 1);
        chk("mid_n_rd", n_rd, 1);
        rst = 1'b0;
        #1;
        chk("mid_rd_en", int'(bus.fifo_rd_en), 0);
        chk("mid_valid", int'(bus.out_valid), 0);
        chk("mid_data", int'(bus.out_data), 0);
        chk("mid_busy", int'(bus.busy), 0);
        restart(0);
        run(5);
        chk("mid_post_busy", int'(bus.busy), 0);
        chk("mid_post_rd", n_rd, 0);

        // Partial burst below threshold.
        restart(2);
`ifdef FIFO_RD_TIMEOUT_EN
        run(40);
        chk("to_first_rd", first_rd, 16);
        chk("to_n_rd", n_rd, 2);
        chk("to_n_out", n_out, 2);
`else
        run(100);
        chk("noto_n_rd", n_rd, 0);
        chk("noto_left", fifo_left(), 2);
`endif

        // Randomized traffic against the scoreboard.
        restart(0);
        for (int i = 0; i < 600; i++) begin
            wr_req = 1'($urandom_range(0, 1));
            wr_val = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        wr_req = 1'b0;
        bus.out_ready = 1'b1;
        run(80);
        chk("rnd_count", wr_total - rd_total, fifo_left());
        if (TO) chk("rnd_left", fifo_left(), 0);
        else chk("rnd_left_lt", int'(fifo_left() < 4), 1);
        chk("rnd_busy", int'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the 8-deep, 4-bit synchronous FIFO (fifo_8_1); the consumer end of the FIFO's write/read interface.
- Watches the FIFO's empty, full and count outputs, then issues rd_en in bursts.
- Captures rd_data one cycle after each pop.
- Presents the words downstream on a valid/ready stream through a 2-entry output buffer, at full throughput with no data loss under backpressure.

Parameters:
- DATA_W, 4, FIFO word width.
- CNT_W, 3, width of the FIFO count input.
- BURST_LEN, 4, FIFO occupancy that starts a burst; also the maximum number of pops per burst (1..8).
- FLUSH_TIMEOUT, 16, idle cycles with a non-empty FIFO before a partial burst is forced (macro-gated).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_cnt  in  CNT_W  FIFO occupancy (wraps to 0 when full; qualify with fifo_full).
- fifo_rd_en  out  1  pop strobe to the FIFO.
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_en.
- out_valid  out  1  downstream word valid.
- out_data  out  DATA_W  downstream word.
- out_ready  in  1  downstream accept.
- busy  out  1  high while in BURST or while the output buffer is non-empty.

Behaviour:
- Reset (rst low, asynchronous):
  - fifo_rd_en=0, out_valid=0, out_data=0, busy=0.
  - FSM goes to IDLE; all counters and buffer pointers clear.
- Occupancy term: occ = fifo_full ? 8 : fifo_cnt.
- FSM states: IDLE, BURST.
  - IDLE -> BURST when occ >= BURST_LEN (or timeout, see Optional Feature). burst_rem loads min(occ, BURST_LEN).
  - BURST -> IDLE when burst_rem reaches 0 or fifo_empty is seen.
- Pop rule (in BURST): fifo_rd_en=1 only when all three hold:
  - !fifo_empty
  - burst_rem != 0
  - buf_occ + inflight − pop_out < 2, where inflight is a 1-bit register holding last cycle's fifo_rd_en and pop_out = out_valid & out_ready.
- Each pop decrements burst_rem.
- fifo_rd_en is combinational from registered state and the FIFO flags; no rd_en ever reaches an empty FIFO.
- Capture: when inflight=1, fifo_rd_data is written into the output buffer that cycle.
- Output buffer (2 entries):
  - out_data/out_valid come from the head entry; order is preserved.
  - Simultaneous write and pop are allowed.
  - Overflow is impossible by the credit rule.
- Throughput: 1 word/cycle sustained while out_ready=1 and the FIFO is non-empty.
- Latency: first rd_en one cycle after the trigger is sampled; out_valid two cycles after rd_en (capture, then buffer output register).
- Backpressure: out_valid and out_data hold stable while out_valid & !out_ready.
- busy = (state==BURST) | (buf_occ != 0) | inflight.
- Reset mid-burst: the in-flight read is discarded and buffered words are lost. Upstream must also reset the FIFO.

Optional Feature:
- Macro: FIFO_RD_TIMEOUT_EN.
- Defined:
  - In IDLE, a timer counts cycles with !fifo_empty and occ < BURST_LEN.
  - When the timer reaches FLUSH_TIMEOUT, the FSM enters BURST with burst_rem = occ.
  - The timer clears on entering BURST, on fifo_empty, and on reset.
- Undefined: no timer logic; words below the threshold stay in the FIFO until occ >= BURST_LEN.

Decomposition:
- Package fifo_rd_pkg holds:
  - state encoding (IDLE=1'b0, BURST=1'b1)
  - FIFO_DEPTH=8
  - default BURST_LEN
  - default FLUSH_TIMEOUT
- One sub-module, rd_out_buf2: 2-entry valid/ready buffer (write port, head output, occupancy count). Instantiated once.

Test Plan:
- Reset then idle: with rst low, all outputs are 0. After release with FIFO empty, fifo_rd_en stays 0 for 50 cycles.
- Threshold burst: write 0,1,2,3 (cnt=4), out_ready=1 -> fifo_rd_en high exactly 4 consecutive cycles; out_data 0,1,2,3 on consecutive cycles, starting 2 cycles after the first rd_en; FSM returns to IDLE.
- Full FIFO: write 10 words 0..9 (the FIFO keeps 0..7, full=1) -> two bursts of 4; output 0..7 in order; fifo_empty at the end; no rd_en while empty.
- Backpressure: 4 words queued, out_ready=0 -> at most 2 pops then rd_en=0, out_data=0 held. Release out_ready -> remaining 2 words popped; output 0,1,2,3, none duplicated or lost.
- Timeout (macro on): write 2 words, wait -> no pop for 15 cycles; burst of 2 starts at cycle 16. Macro off: no pop after 100 cycles.
- Reset mid-burst: assert rst during the 2nd pop -> outputs go to 0 immediately; after release the FSM is in IDLE with busy=0.
